// File: rtl/pe_mac_seq_if.sv
// Beat-in / frame-out handshake bundle for the sequential readout PE.
// master = producer/consumer side, slave = the PE.
interface pe_mac_seq_if #(
  parameter int DW    = 16,
  parameter int N_OUT = 4
);
  logic [1:0]          cfg_mode;
  logic                in_valid;
  logic                in_ready;
  logic [DW-1:0]       in_data;
  logic [N_OUT*DW-1:0] in_wgt;
  logic                in_last;
  logic                out_valid;
  logic                out_ready;
  logic [N_OUT*DW-1:0] out_data;
  logic [N_OUT-1:0]    out_sat;
  logic                err_frame;

  modport master (
    output cfg_mode, in_valid, in_data, in_wgt, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_sat, err_frame
  );

  modport slave (
    input  cfg_mode, in_valid, in_data, in_wgt, in_last, out_ready,
    output in_ready, out_valid, out_data, out_sat, err_frame
  );
endinterface

// File: rtl/pe_mac_seq.sv
// Time-multiplexed ESN readout PE: one input neuron per beat, N_OUT MAC lanes,
// activation + saturation applied on the final beat of each N_IN-beat frame.
module pe_mac_lane #(
  parameter int DW    = 16,
  parameter int ACC_W = 36,
  parameter int FRAC  = 15
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 beat,
  input  logic                 first,
  input  logic [1:0]           mode,
  input  logic signed [DW-1:0] data,
  input  logic signed [DW-1:0] wgt,
  output logic [DW-1:0]        res,
  output logic                 sat
);
  localparam logic signed [ACC_W-1:0] MAXV = {{(ACC_W-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MINV = {{(ACC_W-DW+1){1'b1}}, {(DW-1){1'b0}}};

  logic signed [ACC_W-1:0] acc, prod, sum, s, r;

  always_comb begin
    prod = ACC_W'(data) * ACC_W'(wgt);
    // The first beat overwrites the accumulator, so no clear cycle is needed.
    sum  = (first ? '0 : acc) + prod;
    s    = sum >>> FRAC;
    case (mode)
      2'b01:   r = s[ACC_W-1] ? '0 : s;
      2'b10:   r = s[ACC_W-1] ? (s >>> 3) : s;
      default: r = s;
    endcase
    res = r[DW-1:0];
    sat = 1'b0;
    if (r > MAXV) begin
      res = MAXV[DW-1:0];
      sat = 1'b1;
    end else if (r < MINV) begin
      res = MINV[DW-1:0];
      sat = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n)    acc <= '0;
    else if (beat) acc <= sum;
  end
endmodule

module pe_mac_seq #(
  parameter int DW    = 16,
  parameter int N_IN  = 16,
  parameter int N_OUT = 4,
  parameter int FRAC  = 15
) (
  input logic          clk,
  input logic          rst_n,
  pe_mac_seq_if.slave  bus
);
  localparam int ACC_W = 2*DW + $clog2(N_IN);
  localparam int CW    = $clog2(N_IN);

  logic [CW-1:0]             cnt;
  logic [1:0]                mode_q;
  logic                      last_beat, beat, in_ready;
  logic                      out_valid_q, err_q;
  logic [N_OUT-1:0][DW-1:0]  res, out_data_q;
  logic [N_OUT-1:0]          sat, out_sat_q;

  assign last_beat = (cnt == CW'(N_IN-1));
  // Only the final beat can stall: it needs the output register free.
  assign in_ready  = !(last_beat && out_valid_q && !bus.out_ready);
  assign beat      = bus.in_valid && in_ready;

  for (genvar k = 0; k < N_OUT; k++) begin : g_lane
    pe_mac_lane #(.DW(DW), .ACC_W(ACC_W), .FRAC(FRAC)) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .beat  (beat),
      .first (cnt == '0),
      .mode  (mode_q),
      .data  (bus.in_data),
      .wgt   (bus.in_wgt[k*DW +: DW]),
      .res   (res[k]),
      .sat   (sat[k])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt         <= '0;
      mode_q      <= 2'b00;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      err_q <= beat && (bus.in_last != last_beat);
      if (beat) begin
        cnt <= last_beat ? '0 : cnt + CW'(1);
        if (cnt == '0) mode_q <= bus.cfg_mode;
      end
      if (beat && last_beat) begin
        out_data_q  <= res;
        out_sat_q   <= sat;
        out_valid_q <= 1'b1;
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sat   = out_sat_q;
  assign bus.err_frame = err_q;
endmodule
